// File: rtl/rtc_access_scheduler_if.sv
// Handshake between the RTC access scheduler (master) and the bus transaction engine (slave).
interface rtc_access_scheduler_if;
    logic       bus_req;
    logic       bus_wr;
    logic [7:0] bus_addr;
    logic       bus_done;

    modport master (output bus_req, output bus_wr, output bus_addr, input bus_done);
    modport slave  (input bus_req, input bus_wr, input bus_addr, output bus_done);
endinterface

// File: rtl/rtc_access_scheduler.sv
// Sequences all RTC register traffic: periodic nine-register read bursts and
// change-triggered write bursts with an optional commit transaction.
module rtc_access_scheduler #(
    parameter int READ_PERIOD  = 1000,
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cambio,
    input  logic [1:0]                   write_group,
    rtc_access_scheduler_if.master       bus,
    output logic [3:0]                   reg_index,
    output logic                         capture,
    output logic                         reset_cambio,
    output logic                         busy,
    output logic                         timeout_err
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, CM_REQ, CM_WAIT, CLEAR
    } state_t;

    localparam logic [3:0]       LAST_READ_IDX = 4'd8;
    localparam logic [3:0]       COMMIT_IDX    = 4'd9;
    localparam logic [1:0]       GROUP_TIMER   = 2'd2;
    localparam logic [CNT_W-1:0] PERIOD_LAST   = CNT_W'(READ_PERIOD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(WAIT_TIMEOUT - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] period_cnt, period_cnt_nx;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
    logic [3:0]       index, index_nx;
    logic [1:0]       group, group_nx;
    logic             err_nx;
    logic             xact_open;

    function automatic logic [3:0] first_index(input logic [1:0] g);
        case (g)
            2'd1:    return 4'd3;
            2'd2:    return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] last_index(input logic [1:0] g);
        case (g)
            2'd0:    return 4'd2;
            2'd1:    return 4'd5;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [7:0] addr_of(input logic [3:0] idx);
        case (idx)
            4'd0: return 8'h21;
            4'd1: return 8'h22;
            4'd2: return 8'h23;
            4'd3: return 8'h24;
            4'd4: return 8'h25;
            4'd5: return 8'h26;
            4'd6: return 8'h41;
            4'd7: return 8'h42;
            4'd8: return 8'h43;
            4'd9: return 8'hF1;
            default: return 8'h00;
        endcase
    endfunction

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nx      = state;
        period_cnt_nx = '0;
        wait_cnt_nx   = wait_cnt;
        index_nx      = index;
        group_nx      = group;
        err_nx        = timeout_err;
        capture       = 1'b0;

        case (state)
            IDLE: begin
                period_cnt_nx = period_cnt + CNT_W'(1);
                if (cambio) begin
                    group_nx = write_group;
                    index_nx = first_index(write_group);
                    state_nx = WR_REQ;
                end else if (period_cnt == PERIOD_LAST) begin
                    index_nx = 4'd0;
                    state_nx = RD_REQ;
                end
            end
            RD_REQ: begin
                wait_cnt_nx = '0;
                state_nx    = RD_WAIT;
            end
            WR_REQ: begin
                wait_cnt_nx = '0;
                state_nx    = WR_WAIT;
            end
            CM_REQ: begin
                wait_cnt_nx = '0;
                state_nx    = CM_WAIT;
            end
            RD_WAIT, WR_WAIT, CM_WAIT: begin
                if (bus.bus_done) begin
                    if (state == RD_WAIT) begin
                        capture = 1'b1;
                        if (index == LAST_READ_IDX) begin
                            state_nx = IDLE;
                        end else begin
                            index_nx = index + 4'd1;
                            state_nx = RD_REQ;
                        end
                    end else if (state == WR_WAIT) begin
                        if (index != last_index(group)) begin
                            index_nx = index + 4'd1;
                            state_nx = WR_REQ;
                        end else if (group == GROUP_TIMER) begin
                            state_nx = CLEAR;
                        end else begin
                            index_nx = COMMIT_IDX;
                            state_nx = CM_REQ;
                        end
                    end else begin
                        state_nx = CLEAR;
                    end
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    // Abort without clearing cambio so a pending write is retried.
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + CNT_W'(1);
                end
            end
            CLEAR:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            period_cnt  <= '0;
            wait_cnt    <= '0;
            index       <= '0;
            group       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            period_cnt  <= period_cnt_nx;
            wait_cnt    <= wait_cnt_nx;
            index       <= index_nx;
            group       <= group_nx;
            timeout_err <= err_nx;
        end
    end

    // Address, direction and index are only driven while a transaction is open.
    assign xact_open    = (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ) ||
                          (state == WR_WAIT) || (state == CM_REQ) || (state == CM_WAIT);
    assign bus.bus_req  = (state == RD_REQ) || (state == WR_REQ) || (state == CM_REQ);
    assign bus.bus_wr   = (state == WR_REQ) || (state == WR_WAIT) || (state == CM_REQ) || (state == CM_WAIT);
    assign bus.bus_addr = xact_open ? addr_of(index) : 8'h00;
    assign reg_index    = xact_open ? index : 4'd0;
    assign reset_cambio = (state == CLEAR);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Self-checking bench: transaction-list reference model compared every cycle, plus directed scenarios with literal expectations.
module tb_rtc_access_scheduler;

    localparam int RP = 16;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cambio = 1'b0;
    logic [1:0] write_group = 2'd0;
    logic [3:0] reg_index;
    logic       capture, reset_cambio, busy, timeout_err;

    rtc_access_scheduler_if bif();

    rtc_access_scheduler #(.READ_PERIOD(RP), .WAIT_TIMEOUT(TO), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .cambio       (cambio),
        .write_group  (write_group),
        .bus          (bif),
        .reg_index    (reg_index),
        .capture      (capture),
        .reset_cambio (reset_cambio),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (transaction list) ----------------
    typedef struct {
        logic [3:0] idx;
        logic [7:0] addr;
        logic       wr;
    } item_t;
    typedef enum {M_IDLE, M_REQ, M_WAIT, M_CLEAR} mphase_t;

    logic [7:0] addr_tab [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43, 8'hF1};
    item_t   m_q[$];
    mphase_t m_ph = M_IDLE;
    int      m_pcnt = 0, m_wcnt = 0;
    bit      m_err = 0, m_write = 0, cmp_en = 0;
    int      cyc = 0;

    function automatic void build(input bit wr, input int g);
        int lo, hi;
        item_t it;
        m_q.delete();
        lo = 0; hi = 8;
        if (wr) begin
            lo = (g == 1) ? 3 : (g == 2) ? 6 : 0;
            hi = (g == 0) ? 2 : (g == 1) ? 5 : 8;
        end
        for (int i = lo; i <= hi; i++) begin
            it.idx = 4'(i); it.addr = addr_tab[i]; it.wr = wr;
            m_q.push_back(it);
        end
        if (wr && g != 2) begin
            it.idx = 4'd9; it.addr = addr_tab[9]; it.wr = 1'b1;
            m_q.push_back(it);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rst) begin
            m_ph = M_IDLE; m_pcnt = 0; m_wcnt = 0; m_err = 0; m_q.delete(); cmp_en = 1;
        end else begin
            case (m_ph)
                M_IDLE: begin
                    if (cambio) begin
                        build(1, int'(write_group)); m_write = 1; m_ph = M_REQ;
                    end else if (m_pcnt == RP - 1) begin
                        build(0, 0); m_write = 0; m_ph = M_REQ;
                    end else m_pcnt++;
                end
                M_REQ: begin
                    m_ph = M_WAIT; m_wcnt = 0;
                end
                M_WAIT: begin
                    if (bif.bus_done) begin
                        void'(m_q.pop_front());
                        if (m_q.size() != 0) m_ph = M_REQ;
                        else if (m_write) m_ph = M_CLEAR;
                        else begin m_ph = M_IDLE; m_pcnt = 0; end
                    end else if (m_wcnt == TO - 1) begin
                        m_ph = M_IDLE; m_pcnt = 0; m_err = 1; m_q.delete();
                    end else m_wcnt++;
                end
                M_CLEAR: begin
                    m_ph = M_IDLE; m_pcnt = 0;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare, logging and bus responder scheduling ----------------
    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic       wr;
        logic [3:0] idx;
    } req_t;

    req_t req_log[$];
    int   cap_log[$];
    int   rc_log[$];
    int   last_rc_cyc = -10;
    int   due = -1;
    int   lat_fix = 3;
    bit   lat_rand = 0, silent = 0, noise = 0;

    always @(negedge clk) begin
        bit   open;
        req_t r;
        if (cmp_en) begin
            open = (m_ph == M_REQ) || (m_ph == M_WAIT);
            check("busy",         busy,          m_ph != M_IDLE);
            check("bus_req",      bif.bus_req,   m_ph == M_REQ);
            check("bus_wr",       bif.bus_wr,    open ? m_q[0].wr : 1'b0);
            check("bus_addr",     bif.bus_addr,  open ? m_q[0].addr : 8'h00);
            check("reg_index",    reg_index,     open ? m_q[0].idx : 4'd0);
            check("capture",      capture,       (m_ph == M_WAIT) && !m_write && bif.bus_done);
            check("reset_cambio", reset_cambio,  m_ph == M_CLEAR);
            check("timeout_err",  timeout_err,   m_err);
        end
        if (bif.bus_req) begin
            r.cyc = cyc; r.addr = bif.bus_addr; r.wr = bif.bus_wr; r.idx = reg_index;
            req_log.push_back(r);
            due = cyc + (lat_rand ? int'($urandom_range(1, 9)) : lat_fix);
        end
        if (capture) cap_log.push_back(int'(reg_index));
        if (reset_cambio) begin
            rc_log.push_back(cyc);
            last_rc_cyc = cyc;
        end
    end

    // One clock of stimulus: the change detector drops cambio after reset_cambio; the engine answers bus_req.
    task automatic tick();
        @(posedge clk);
        #1;
        if (last_rc_cyc == cyc - 1) cambio = 1'b0;
        bif.bus_done = (!silent && cyc == due) || (noise && $urandom_range(15) == 0);
    endtask

    task automatic clear_logs();
        req_log.delete(); cap_log.delete(); rc_log.delete();
    endtask

    task automatic wait_reqs(input int n, input int budget, input string name);
        int k = 0;
        while (req_log.size() < n && k < budget) begin tick(); k++; end
        check(name, req_log.size() >= n, 1);
    endtask

    task automatic wait_rc(input int budget, input string name);
        int k = 0;
        while (rc_log.size() == 0 && k < budget) begin tick(); k++; end
        check(name, rc_log.size() > 0, 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy && k < budget) begin tick(); k++; end
        check(name, busy, 0);
    endtask

    logic [7:0] rd_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    logic [7:0] all_wr  [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43, 8'hF1};

    initial begin
        int c0, b, t, k;
        bif.bus_done = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_addr", bif.bus_addr, 8'h00);
        check("rst_err",  timeout_err, 0);
        rst = 1'b1;
        c0 = cyc;
        clear_logs();

        // Periodic read
        wait_reqs(10, 200, "read_bursts_seen");
        check("first_req_delay", req_log[0].cyc - c0, 16);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("rd_addr%0d", i), req_log[i].addr, rd_addr[i]);
            check($sformatf("rd_wr%0d", i),   req_log[i].wr, 0);
            check($sformatf("rd_idx%0d", i),  req_log[i].idx, i);
        end
        check("capture_count", cap_log.size() >= 9, 1);
        for (int i = 0; i < 9; i++) check($sformatf("cap_idx%0d", i), cap_log[i], i);
        check("burst_gap", req_log[9].cyc - req_log[8].cyc, 20);

        // Time write with commit
        wait_idle(200, "idle_before_time_write");
        clear_logs();
        cambio = 1'b1; write_group = 2'd0;
        wait_rc(200, "time_write_done");
        check("time_wr_count", req_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("time_addr%0d", i), req_log[i].addr, (i < 3) ? rd_addr[i] : 8'hF1);
            check($sformatf("time_wr%0d", i),   req_log[i].wr, 1);
        end
        check("time_rc_delay", rc_log[0] - req_log[3].cyc, 4);
        check("time_no_capture", cap_log.size(), 0);

        // Timer write: no commit; write_group change mid-burst is ignored
        wait_idle(200, "idle_before_timer_write");
        clear_logs();
        cambio = 1'b1; write_group = 2'd2;
        tick(); tick();
        write_group = 2'd1;
        wait_rc(200, "timer_write_done");
        check("timer_wr_count", req_log.size(), 3);
        for (int i = 0; i < 3; i++) check($sformatf("timer_addr%0d", i), req_log[i].addr, rd_addr[6 + i]);
        check("timer_rc_delay", rc_log[0] - req_log[2].cyc, 4);

        // Collision: cambio on the cycle the period counter reaches RP-1
        wait_idle(200, "idle_before_collision");
        b = cyc;
        repeat (RP - 1) tick();
        clear_logs();
        cambio = 1'b1; write_group = 2'd1;
        wait_rc(200, "collision_write_done");
        wait_reqs(5, 200, "collision_read_seen");
        check("coll_first_delay", req_log[0].cyc - b, 16);
        check("coll_first_wr", req_log[0].wr, 1);
        check("coll_first_addr", req_log[0].addr, 8'h24);
        check("coll_commit_addr", req_log[3].addr, 8'hF1);
        check("coll_read_wr", req_log[4].wr, 0);
        check("coll_read_addr", req_log[4].addr, 8'h21);
        check("coll_read_delay", req_log[4].cyc - rc_log[0], 17);

        // Timeout during a write, then retry of the same burst
        wait_idle(200, "idle_before_timeout");
        clear_logs();
        silent = 1'b1;
        cambio = 1'b1; write_group = 2'd3;
        wait_reqs(2, 100, "timeout_retry_seen");
        check("timeout_retry_gap", req_log[1].cyc - req_log[0].cyc, 10);
        check("timeout_retry_idx", req_log[1].idx, 0);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_no_rc", rc_log.size(), 0);
        silent = 1'b0;
        wait_rc(300, "all_write_done");
        check("all_wr_count", req_log.size(), 11);
        for (int i = 0; i < 10; i++) check($sformatf("all_addr%0d", i), req_log[1 + i].addr, all_wr[i]);
        check("timeout_err_sticky", timeout_err, 1);

        // Reset during RD_WAIT of index 4
        wait_idle(200, "idle_before_reset_test");
        k = 0;
        while (!(bif.bus_req && reg_index == 4'd4 && !bif.bus_wr) && k < 200) begin tick(); k++; end
        check("reached_rd_idx4", bif.bus_req && reg_index == 4'd4, 1);
        t = cyc;
        tick();
        rst = 1'b0;
        tick();
        check("mid_rst_cycle", cyc - t, 2);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_req", bif.bus_req, 0);
        check("mid_rst_wr", bif.bus_wr, 0);
        check("mid_rst_addr", bif.bus_addr, 8'h00);
        check("mid_rst_idx", reg_index, 0);
        check("mid_rst_cap", capture, 0);
        check("mid_rst_rc", reset_cambio, 0);
        check("mid_rst_err", timeout_err, 0);
        rst = 1'b1;
        c0 = cyc;
        clear_logs();
        wait_reqs(1, 100, "restart_read_seen");
        check("restart_idx", req_log[0].idx, 0);
        check("restart_addr", req_log[0].addr, 8'h21);
        check("restart_delay", req_log[0].cyc - c0, 16);
        check("restart_no_rc", rc_log.size(), 0);

        // Randomised traffic: variable latency (including timeouts), stray bus_done, mid-burst resets
        lat_rand = 1'b1;
        noise = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            tick();
            if (!cambio && $urandom_range(19) == 0) begin
                cambio = 1'b1;
                write_group = 2'($urandom_range(3));
            end
            if ($urandom_range(7) == 0) write_group = 2'($urandom_range(3));
            rst = ($urandom_range(599) == 0) ? 1'b0 : 1'b1;
        end
        rst = 1'b1;
        noise = 1'b0;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
